// File: rtl/gate_pipe_unit_if.sv
// Handshake and data bundle for gate_pipe_unit: operand input side,
// result output side, and the completed-transfer counter.
interface gate_pipe_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [CNT_W-1:0] done_cnt;

    modport master (
        output in_valid, a, b, c, op, out_ready,
        input  in_ready, out_valid, y, zero, done_cnt
    );

    modport slave (
        input  in_valid, a, b, c, op, out_ready,
        output in_ready, out_valid, y, zero, done_cnt
    );
endinterface

// File: rtl/gate_pipe_unit.sv
// Two-stage bitwise logic pipeline: S1 captures operands and op, S2 holds the
// registered result with a zero flag; valid/ready on both sides.
module gate_pipe_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_pipe_unit_if.slave  bus
);
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [2:0]       op_q, op_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_ready;
    logic             in_xfer;
    logic             out_xfer;
    logic             s2_load;
    logic [WIDTH-1:0] res;

    // S2 is free when empty or draining this edge; S1 can then always accept.
    assign s2_load  = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign in_ready = !s1_valid_q || !out_valid_q || bus.out_ready;
    assign in_xfer  = bus.in_valid && in_ready;
    assign out_xfer = out_valid_q && bus.out_ready;

    always_comb begin
        res = a_q;
        case (op_q)
            3'd0:    res = a_q & b_q;
            3'd1:    res = a_q | b_q;
            3'd2:    res = a_q ^ b_q;
            3'd3:    res = ~(a_q & b_q);
            3'd4:    res = ~(a_q | b_q);
            3'd5:    res = ~(a_q ^ b_q);
            3'd6:    res = ~((a_q | b_q) ^ c_q);
            default: res = a_q;
        endcase
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        op_d        = op_q;
        s1_valid_d  = s1_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        if (in_xfer) begin
            a_d        = bus.a;
            b_d        = bus.b;
            c_d        = bus.c;
            op_d       = bus.op;
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            y_d         = res;
            zero_d      = (res == '0);
            out_valid_d = 1'b1;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (out_xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            op_q        <= '0;
            s1_valid_q  <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            op_q        <= op_d;
            s1_valid_q  <= s1_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.done_cnt  = cnt_q;
endmodule
